// File: rtl/phase_wave_ctrl_if.sv
// Configuration port bundle for phase_wave_ctrl.
// cfg_ncyc exists only when PHASE_WAVE_NCYC_EN is defined.
interface phase_wave_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_phase;
    logic [CNT_W-1:0] cfg_ton;
    logic [CNT_W-1:0] cfg_toff;
`ifdef PHASE_WAVE_NCYC_EN
    logic [CNT_W-1:0] cfg_ncyc;

    modport master (
        output cfg_valid, cfg_phase, cfg_ton, cfg_toff, cfg_ncyc,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_phase, cfg_ton, cfg_toff, cfg_ncyc,
        output cfg_ready
    );
`else
    modport master (
        output cfg_valid, cfg_phase, cfg_ton, cfg_toff,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_phase, cfg_ton, cfg_toff,
        output cfg_ready
    );
`endif
endinterface

// File: rtl/phase_wave_ctrl.sv
// Programmable phase/high/low waveform generator with shadowed config.
// Optional PHASE_WAVE_NCYC_EN adds an auto-stop after cfg_ncyc periods.
module phase_wave_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    phase_wave_ctrl_if.slave cfg,
    input  logic             start,
    input  logic             stop,
    output logic             wave_out,
    output logic             busy,
    output logic             period_done
);
    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Reload value for a hold time; 0 behaves like 1.
    function automatic logic [CNT_W-1:0] load(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic [CNT_W-1:0] sh_phase, sh_ton, sh_toff;
    logic [CNT_W-1:0] phase_q, ton_q, toff_q;
    logic             accept, apply, last, run_end;
    logic [CNT_W-1:0] phase_n, ton_n;

    assign cfg.cfg_ready = !pending;

    // Handshake and boundary-copy decisions.
    always_comb begin
        last    = (cnt == '0);
        accept  = cfg.cfg_valid && !pending;
        apply   = pending &&
                  (state == IDLE || (state == LOW && last && !stop));
        phase_n = apply ? sh_phase : phase_q;
        ton_n   = apply ? sh_ton : ton_q;
    end

`ifdef PHASE_WAVE_NCYC_EN
    logic [CNT_W-1:0] sh_ncyc, ncyc_q, ncnt;

    // Last period of a bounded run; ncyc of 0 never ends.
    always_comb begin
        run_end = (ncyc_q != '0) && (ncnt == ncyc_q - ONE);
    end

    // Completed-period counter for the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncnt <= '0;
        end else if (stop || state == IDLE) begin
            ncnt <= '0;
        end else if (state == LOW && last) begin
            ncnt <= ncnt + ONE;
        end
    end
`else
    assign run_end = 1'b0;
`endif

    // Shadow capture on accept, active copy on apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            sh_phase <= '0;
            sh_ton   <= '0;
            sh_toff  <= '0;
            phase_q  <= '0;
            ton_q    <= ONE;
            toff_q   <= ONE;
`ifdef PHASE_WAVE_NCYC_EN
            sh_ncyc  <= '0;
            ncyc_q   <= '0;
`endif
        end else if (apply) begin
            pending  <= 1'b0;
            phase_q  <= sh_phase;
            ton_q    <= sh_ton;
            toff_q   <= sh_toff;
`ifdef PHASE_WAVE_NCYC_EN
            ncyc_q   <= sh_ncyc;
`endif
        end else if (accept) begin
            pending  <= 1'b1;
            sh_phase <= cfg.cfg_phase;
            sh_ton   <= cfg.cfg_ton;
            sh_toff  <= cfg.cfg_toff;
`ifdef PHASE_WAVE_NCYC_EN
            sh_ncyc  <= cfg.cfg_ncyc;
`endif
        end
    end

    // Main FSM; outputs are registered from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wave_out    <= 1'b0;
            busy        <= 1'b0;
            period_done <= 1'b0;
        end else begin
            wave_out    <= (state == HIGH) && !stop;
            period_done <= (state == LOW) && last && !stop;
            if (stop) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (phase_n != '0) begin
                                state <= PHASE;
                                cnt   <= phase_n - ONE;
                            end else begin
                                state <= HIGH;
                                cnt   <= load(ton_n);
                            end
                        end
                    end
                    PHASE: begin
                        if (last) begin
                            state <= HIGH;
                            cnt   <= load(ton_q);
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    HIGH: begin
                        if (last) begin
                            state <= LOW;
                            cnt   <= load(toff_q);
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    LOW: begin
                        if (last && run_end) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (last) begin
                            state <= HIGH;
                            cnt   <= load(ton_n);
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_phase_wave_ctrl.sv
// Directed self-checking bench for phase_wave_ctrl.
// Exercises PHASE_WAVE_NCYC_EN paths only when that macro is defined.
module tb_phase_wave_ctrl;
    logic clk;
    logic rst_n;
    logic start;
    logic stop;
    logic wave_out;
    logic busy;
    logic period_done;

    int n_checks = 0;
    int n_fail   = 0;

    phase_wave_ctrl_if #(.CNT_W(16)) bus ();

    phase_wave_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (bus),
        .start       (start),
        .stop        (stop),
        .wave_out    (wave_out),
        .busy        (busy),
        .period_done (period_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected waveform from spec timing; i = 0 is the point after the start edge.
    function automatic bit exp_w(int i, int p, int on, int off);
        int e_on, e_off, pos;
        e_on  = (on == 0) ? 1 : on;
        e_off = (off == 0) ? 1 : off;
        if (i <= p) return 1'b0;
        pos = (i - p - 1) % (e_on + e_off);
        return pos < e_on;
    endfunction

    function automatic bit exp_pd(int i, int p, int on, int off);
        int e_on, e_off, pos;
        e_on  = (on == 0) ? 1 : on;
        e_off = (off == 0) ? 1 : off;
        if (i <= p) return 1'b0;
        pos = (i - p - 1) % (e_on + e_off);
        return pos == e_on + e_off - 1;
    endfunction

    // Offer one word and wait (bounded) for it to be taken.
    task automatic send_cfg(int p, int on, int off, int nc);
        bit rdy;
        bit done;
        done = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_phase = 16'(p);
        bus.cfg_ton   = 16'(on);
        bus.cfg_toff  = 16'(off);
`ifdef PHASE_WAVE_NCYC_EN
        bus.cfg_ncyc  = 16'(nc);
`else
        if (nc != 0) $display("note: ncyc ignored in this build");
`endif
        for (int k = 0; k < 50 && !done; k++) begin
            rdy = bus.cfg_ready;
            step();
            if (rdy) done = 1'b1;
        end
        bus.cfg_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL cfg_accept_timeout got=0 want=1");
        end
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({wave_out, busy, period_done, bus.cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=0001",
                     {wave_out, busy, period_done, bus.cfg_ready});
        end
    endtask

    task automatic test_basic();
        send_cfg(0, 5, 5, 0);
        do_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_rise got=%b want=1", busy);
        end
        for (int i = 0; i <= 30; i++) begin
            n_checks++;
            if (wave_out !== exp_w(i, 0, 5, 5)) begin
                n_fail++;
                $display("FAIL basic_wave i=%0d got=%b want=%b",
                         i, wave_out, exp_w(i, 0, 5, 5));
            end
            n_checks++;
            if (period_done !== exp_pd(i, 0, 5, 5)) begin
                n_fail++;
                $display("FAIL basic_pd i=%0d got=%b want=%b",
                         i, period_done, exp_pd(i, 0, 5, 5));
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_phase();
        send_cfg(10, 3, 7, 0);
        do_start();
        for (int i = 0; i <= 40; i++) begin
            n_checks++;
            if (wave_out !== exp_w(i, 10, 3, 7)) begin
                n_fail++;
                $display("FAIL phase_wave i=%0d got=%b want=%b",
                         i, wave_out, exp_w(i, 10, 3, 7));
            end
            n_checks++;
            if (period_done !== exp_pd(i, 10, 3, 7)) begin
                n_fail++;
                $display("FAIL phase_pd i=%0d got=%b want=%b",
                         i, period_done, exp_pd(i, 10, 3, 7));
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_reconfig();
        int  nacc, acc1, acc2, pos;
        bit  ew, ep, rdy;
        nacc = 0;
        acc1 = -1;
        acc2 = -1;
        send_cfg(0, 5, 5, 0);
        do_start();
        for (int i = 0; i <= 30; i++) begin
            if (i <= 10) begin
                ew = (i >= 1 && i <= 5);
                ep = (i == 10);
            end else begin
                pos = (i - 11) % 4;
                ew  = pos < 2;
                ep  = pos == 3;
            end
            n_checks++;
            if (wave_out !== ew) begin
                n_fail++;
                $display("FAIL reconf_wave i=%0d got=%b want=%b", i, wave_out, ew);
            end
            n_checks++;
            if (period_done !== ep) begin
                n_fail++;
                $display("FAIL reconf_pd i=%0d got=%b want=%b", i, period_done, ep);
            end
            if (i >= 3 && i <= 10) begin
                n_checks++;
                if (bus.cfg_ready !== (i == 10)) begin
                    n_fail++;
                    $display("FAIL reconf_ready i=%0d got=%b want=%b",
                             i, bus.cfg_ready, (i == 10));
                end
            end
            if (i == 2) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_phase = 16'd0;
                bus.cfg_ton   = 16'd2;
                bus.cfg_toff  = 16'd2;
`ifdef PHASE_WAVE_NCYC_EN
                bus.cfg_ncyc  = 16'd0;
`endif
            end
            rdy = bus.cfg_ready;
            step();
            if (bus.cfg_valid && rdy) begin
                nacc++;
                if (nacc == 1) begin
                    acc1 = i + 1;
                end else begin
                    acc2 = i + 1;
                    bus.cfg_valid = 1'b0;
                end
            end
        end
        bus.cfg_valid = 1'b0;
        n_checks++;
        if (acc1 !== 3) begin
            n_fail++;
            $display("FAIL reconf_first_accept got=%0d want=3", acc1);
        end
        n_checks++;
        if (acc2 !== 11) begin
            n_fail++;
            $display("FAIL reconf_stall_accept got=%0d want=11", acc2);
        end
        do_stop();
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if ({busy, wave_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL startstop_idle got=%b want=00", {busy, wave_out});
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL startstop_stays_idle got=%b want=0", busy);
        end
        do_start();
        step();
        n_checks++;
        if (wave_out !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_pre_high got=%b want=1", wave_out);
        end
        do_stop();
        n_checks++;
        if ({wave_out, busy, period_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_mid_high got=%b want=000",
                     {wave_out, busy, period_done});
        end
        step();
        n_checks++;
        if ({wave_out, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_stays got=%b want=00", {wave_out, busy});
        end
    endtask

    task automatic test_clamp();
        send_cfg(0, 0, 0, 0);
        do_start();
        for (int i = 0; i <= 12; i++) begin
            n_checks++;
            if (wave_out !== exp_w(i, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL clamp_wave i=%0d got=%b want=%b",
                         i, wave_out, exp_w(i, 0, 0, 0));
            end
            n_checks++;
            if (period_done !== exp_pd(i, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL clamp_pd i=%0d got=%b want=%b",
                         i, period_done, exp_pd(i, 0, 0, 0));
            end
            step();
        end
        do_stop();
    endtask

    task automatic test_async_reset();
        send_cfg(0, 5, 5, 0);
        do_start();
        repeat (7) step();
        bus.cfg_valid = 1'b1;
        bus.cfg_phase = 16'd1;
        bus.cfg_ton   = 16'd1;
        bus.cfg_toff  = 16'd1;
        step();
        bus.cfg_valid = 1'b0;
        n_checks++;
        if ({busy, bus.cfg_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL arst_pre got=%b want=10", {busy, bus.cfg_ready});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wave_out, busy, period_done, bus.cfg_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL arst_immediate got=%b want=0001",
                     {wave_out, busy, period_done, bus.cfg_ready});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({wave_out, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_after got=%b want=00", {wave_out, busy});
        end
    endtask

`ifdef PHASE_WAVE_NCYC_EN
    task automatic test_ncyc();
        int npd;
        npd = 0;
        send_cfg(0, 2, 2, 3);
        do_start();
        for (int i = 0; i <= 20; i++) begin
            if (period_done === 1'b1) npd++;
            if (i == 11) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ncyc_busy_before got=%b want=1", busy);
                end
            end
            if (i == 12) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ncyc_busy_drop got=%b want=0", busy);
                end
            end
            step();
        end
        n_checks++;
        if (npd !== 3) begin
            n_fail++;
            $display("FAIL ncyc_pulses got=%0d want=3", npd);
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_phase = '0;
        bus.cfg_ton   = '0;
        bus.cfg_toff  = '0;
`ifdef PHASE_WAVE_NCYC_EN
        bus.cfg_ncyc  = '0;
`endif
        test_reset();
        test_basic();
        test_phase();
        test_reconfig();
        test_start_stop();
        test_clamp();
        test_async_reset();
`ifdef PHASE_WAVE_NCYC_EN
        test_ncyc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
